// File: rtl/alu_pkg.sv
// Shared ALU definitions for the execute stage.
//   - Function-class constants carried on fn[5:4].
//   - Full function codes used by the integer and address pipes.
//   - alu_req_t bundles one ALU operation (operands plus function code).
//   - fn_class() extracts the class field from a full function code.
package alu_pkg;

   localparam int ALU_WIDTH = 32;
   localparam int ALU_FN_W  = 6;

   localparam logic [1:0] FN_CMP   = 2'b00;
   localparam logic [1:0] FN_ARITH = 2'b01;
   localparam logic [1:0] FN_BOOL  = 2'b10;
   localparam logic [1:0] FN_SHIFT = 2'b11;

   localparam logic [ALU_FN_W-1:0] FN_ADD = 6'b010000;
   localparam logic [ALU_FN_W-1:0] FN_SUB = 6'b010001;

   typedef struct packed {
      logic [ALU_WIDTH-1:0] a;
      logic [ALU_WIDTH-1:0] b;
      logic [ALU_FN_W-1:0]  fn;
   } alu_req_t;

   function automatic logic [1:0] fn_class(input logic [ALU_FN_W-1:0] fn);
      return fn[5:4];
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
//   req_i        : request bits, one per requester
//   last_grant_i : index of the requester granted most recently
//   en_i         : grants are only issued when high
//   gnt_o        : one-hot grant (all zero when nothing is granted)
// On a tie the requester that did not win last time is granted.
module rr_arbiter2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);

   assign gnt_o[0] = en_i & req_i[0] & (~req_i[1] |  last_grant_i);
   assign gnt_o[1] = en_i & req_i[1] & (~req_i[0] | ~last_grant_i);

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational execute-stage ALU between two requesters.
//   req0_* : integer pipe (valid/ready request, a/b operands, fn code)
//   req1_* : address/branch-compare helper (same set)
//   rsp0_*, rsp1_* : response valid/ready and result data per requester
//   alu_a/alu_b/alu_fn : drive to the external ALU, alu_y its result
// An accepted operation's ALU result is captured into a one-entry slot
// tagged with its owner, giving a fixed one-cycle response latency.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int FN_W  = 6
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [FN_W-1:0]  req0_fn,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_y,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [FN_W-1:0]  req1_fn,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_y,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [FN_W-1:0]  alu_fn,
   input  logic [WIDTH-1:0] alu_y
);

   logic             slot_full_q;
   logic             slot_owner_q;
   logic [WIDTH-1:0] slot_y_q;
   logic             last_grant_q;

   logic             owner_rsp_ready;
   logic             drain;
   logic             free;
   logic [1:0]       gnt;

   assign owner_rsp_ready = slot_owner_q ? rsp1_ready : rsp0_ready;
   assign drain           = slot_full_q & owner_rsp_ready;
   assign free            = ~slot_full_q | owner_rsp_ready;

   // Gating with n_rst keeps both readies low while reset is held, even
   // if a requester is presenting valid during reset.
   rr_arbiter2 u_arb (
      .req_i        ({req1_valid, req0_valid}),
      .last_grant_i (last_grant_q),
      .en_i         (free & n_rst),
      .gnt_o        (gnt)
   );

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      alu_a  = '0;
      alu_b  = '0;
      alu_fn = '0;
      if (gnt[0]) begin
         alu_a  = req0_a;
         alu_b  = req0_b;
         alu_fn = req0_fn;
      end else if (gnt[1]) begin
         alu_a  = req1_a;
         alu_b  = req1_b;
         alu_fn = req1_fn;
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         // NOTE: the slot is a single register, so it is reset along with
         // its flags; a large data array would normally be left unreset.
         slot_full_q  <= 1'b0;
         slot_owner_q <= 1'b0;
         slot_y_q     <= '0;
         last_grant_q <= 1'b1;
      end else if (|gnt) begin
         slot_full_q  <= 1'b1;
         slot_owner_q <= gnt[1];
         slot_y_q     <= alu_y;
         last_grant_q <= gnt[1];
      end else if (drain) begin
         slot_full_q  <= 1'b0;
      end
   end

   assign rsp0_valid = slot_full_q & ~slot_owner_q;
   assign rsp1_valid = slot_full_q &  slot_owner_q;
   assign rsp0_y     = slot_y_q;
   assign rsp1_y     = slot_y_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter. A small behavioural
// ALU closes the loop between alu_a/alu_b/alu_fn and alu_y.
module tb_alu_share_arbiter;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [5:0]  req0_fn = '0, req1_fn = '0;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [31:0] rsp0_y, rsp1_y;
   logic [31:0] alu_a, alu_b, alu_y;
   logic [5:0]  alu_fn;

   int n_checks = 0;
   int n_bad    = 0;

   always #5 clk = ~clk;

   always_comb begin
      alu_y = alu_a ^ alu_b;
      if (alu_fn == FN_ADD) alu_y = alu_a + alu_b;
      else if (alu_fn == FN_SUB) alu_y = alu_a - alu_b;
   end

   alu_share_arbiter #(.WIDTH(32), .FN_W(6)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_fn    (req0_fn),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp0_y     (rsp0_y),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_fn    (req1_fn),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp1_y     (rsp1_y),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_fn     (alu_fn),
      .alu_y      (alu_y)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] fn);
      req0_valid = v; req0_a = a; req0_b = b; req0_fn = fn;
   endtask

   task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] fn);
      req1_valid = v; req1_a = a; req1_b = b; req1_fn = fn;
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
      check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
      check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      check("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
      n_rst = 1'b1;
      step();

      // 1. Single add
      rsp0_ready = 1'b1;
      drive0(1'b1, 32'd5, 32'd7, FN_ADD);
      #1;
      check("t1_req0_ready", {31'd0, req0_ready}, 32'd1);
      check("t1_alu_fn", {26'd0, alu_fn}, 32'b010000);
      check("t1_alu_a", alu_a, 32'd5);
      step();
      drive0(1'b0, 32'd0, 32'd0, 6'd0);
      #1;
      check("t1_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      check("t1_rsp0_y", rsp0_y, 32'd12);
      check("t1_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
      step();

      // 2. Tie after reset: grants alternate 0,1,0,1
      n_rst = 1'b0;
      #2;
      n_rst = 1'b1;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      drive0(1'b1, 32'd1, 32'd10, FN_ADD);
      drive1(1'b1, 32'd100, 32'd1, FN_SUB);
      #1;
      check("t2_c0_req0_ready", {31'd0, req0_ready}, 32'd1);
      check("t2_c0_req1_ready", {31'd0, req1_ready}, 32'd0);
      step();
      drive0(1'b1, 32'd2, 32'd20, FN_ADD);
      #1;
      check("t2_c1_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      check("t2_c1_rsp0_y", rsp0_y, 32'd11);
      check("t2_c1_req1_ready", {31'd0, req1_ready}, 32'd1);
      check("t2_c1_req0_ready", {31'd0, req0_ready}, 32'd0);
      step();
      drive1(1'b1, 32'd50, 32'd8, FN_SUB);
      #1;
      check("t2_c2_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      check("t2_c2_rsp1_y", rsp1_y, 32'd99);
      check("t2_c2_req0_ready", {31'd0, req0_ready}, 32'd1);
      step();
      drive0(1'b1, 32'd7, 32'd7, FN_ADD);
      #1;
      check("t2_c3_rsp0_y", rsp0_y, 32'd22);
      check("t2_c3_req1_ready", {31'd0, req1_ready}, 32'd1);
      step();
      drive0(1'b0, 32'd0, 32'd0, 6'd0);
      drive1(1'b0, 32'd0, 32'd0, 6'd0);
      #1;
      check("t2_c4_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      check("t2_c4_rsp1_y", rsp1_y, 32'd42);
      check("t2_c4_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      step();

      // 3. Backpressure: owner stalls, other requester is blocked
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      drive0(1'b1, 32'd10, 32'd3, FN_SUB);
      #1;
      check("t3_req0_ready", {31'd0, req0_ready}, 32'd1);
      check("t3_alu_fn", {26'd0, alu_fn}, {26'd0, FN_SUB});
      step();
      drive0(1'b0, 32'd0, 32'd0, 6'd0);
      drive1(1'b1, 32'd1, 32'd1, FN_ADD);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t3_stall_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
         check("t3_stall_rsp0_y", rsp0_y, 32'd7);
         check("t3_stall_req1_ready", {31'd0, req1_ready}, 32'd0);
         step();
      end
      rsp0_ready = 1'b1;
      #1;
      check("t3_release_req1_ready", {31'd0, req1_ready}, 32'd1);
      step();

      // 4. Drain of req1 result plus accept of req0 in the same cycle
      drive1(1'b0, 32'd0, 32'd0, 6'd0);
      rsp1_ready = 1'b1;
      drive0(1'b1, 32'd3, 32'd4, FN_ADD);
      #1;
      check("t4_rsp1_y", rsp1_y, 32'd2);
      check("t4_req0_ready", {31'd0, req0_ready}, 32'd1);
      step();
      drive0(1'b0, 32'd0, 32'd0, 6'd0);
      #1;
      check("t4_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      check("t4_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
      check("t4_rsp0_y", rsp0_y, 32'd7);
      step();

      // 5. Reset mid-operation discards the pending result
      rsp1_ready = 1'b0;
      drive1(1'b1, 32'd9, 32'd4, FN_SUB);
      #1;
      check("t5_req1_ready", {31'd0, req1_ready}, 32'd1);
      step();
      drive1(1'b0, 32'd0, 32'd0, 6'd0);
      #1;
      check("t5_rsp1_valid_before", {31'd0, rsp1_valid}, 32'd1);
      check("t5_rsp1_y", rsp1_y, 32'd5);
      #1;
      n_rst = 1'b0;
      #1;
      check("t5_rsp1_valid_in_rst", {31'd0, rsp1_valid}, 32'd0);
      n_rst = 1'b1;
      drive0(1'b1, 32'd20, 32'd5, FN_ADD);
      drive1(1'b1, 32'd30, 32'd5, FN_SUB);
      #1;
      check("t5_rsp1_valid_after", {31'd0, rsp1_valid}, 32'd0);
      check("t5_tie_req0_ready", {31'd0, req0_ready}, 32'd1);
      check("t5_tie_req1_ready", {31'd0, req1_ready}, 32'd0);
      step();
      drive0(1'b0, 32'd0, 32'd0, 6'd0);
      drive1(1'b0, 32'd0, 32'd0, 6'd0);
      #1;
      check("t5_rsp0_y", rsp0_y, 32'd25);
      check("t5_rsp1_valid_none", {31'd0, rsp1_valid}, 32'd0);
      step();

      // 6. Idle: ALU inputs zero, last grant untouched
      for (int i = 0; i < 10; i++) begin
         check("t6_alu_a", alu_a, 32'd0);
         check("t6_alu_b", alu_b, 32'd0);
         check("t6_alu_fn", {26'd0, alu_fn}, 32'd0);
         check("t6_req0_ready", {31'd0, req0_ready}, 32'd0);
         step();
      end
      rsp1_ready = 1'b1;
      drive0(1'b1, 32'd1, 32'd2, FN_ADD);
      drive1(1'b1, 32'd3, 32'd4, FN_ADD);
      #1;
      check("t6_tie_req1_ready", {31'd0, req1_ready}, 32'd1);
      check("t6_tie_req0_ready", {31'd0, req0_ready}, 32'd0);
      step();
      drive0(1'b0, 32'd0, 32'd0, 6'd0);
      drive1(1'b0, 32'd0, 32'd0, 6'd0);
      #1;
      check("t6_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      check("t6_rsp1_y", rsp1_y, 32'd7);
      step();

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single combinational execute-stage ALU between two requesters: requester 0 is the integer pipe and requester 1 is the address/branch-compare helper. Each requester uses a valid/ready handshake. Arbitration is round-robin. The arbiter drives the ALU operands and function code and registers the ALU result in a one-entry response slot tagged with its owner, so every accepted operation has fixed 1-cycle latency. The external ALU instance is wired between alu_a/alu_b/alu_fn and alu_y.

Parameters:
WIDTH, 32, operand/result width
FN_W, 6, ALU function-code width

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a, req0_b  in  WIDTH  requester 0 operands
req0_fn  in  FN_W  requester 0 ALU function
rsp0_valid  out  1  result for requester 0 held in slot
rsp0_ready  in  1  requester 0 consumes result
rsp0_y  out  WIDTH  result data for requester 0
req1_*/rsp1_*  same set as requester 0  requester 1
alu_a, alu_b  out  WIDTH  operands to ALU
alu_fn  out  FN_W  function to ALU
alu_y  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_fn)

Behaviour:
- Reset (async, n_rst=0): slot_full=0, slot_owner=0, slot_y=0, last_grant=1 (requester 0 wins the first tie). All ready and rsp_valid outputs read 0. Clearing is immediate and does not wait for a clock edge.
- Slot-free condition: free = !slot_full | (rspX_valid & rspX_ready), where X = slot_owner. A response drain and a new accept in the same cycle is legal and gives full throughput.
- Grant, combinational:
  - Only valid requesters are eligible, and only when free=1.
  - One eligible requester: it is granted.
  - Both eligible: the requester != last_grant is granted.
  - reqi_ready = grant_i. Ready may depend on valid; valid must not depend on ready.
- ALU drive: when grant_i=1, alu_a/alu_b/alu_fn = reqi_a/b/fn. With no grant, all three are driven to 0.
- Accept (posedge, grant_i=1):
  - slot_y <= alu_y, slot_owner <= i, slot_full <= 1, last_grant <= i.
  - rspi_valid rises in the cycle after the accept edge (latency 1).
- Drain with no new grant: slot_full <= 0. slot_y is held; it is don't-care when empty.
- Output gating: rspi_valid = slot_full & (slot_owner==i); rspi_y = slot_y for both requesters.
- Backpressure: while the slot is full and its owner's rsp_ready=0, both req_ready outputs are 0. Head-of-line blocking across requesters is intended.
- Stall stability: slot_y, slot_owner and rsp_valid hold stable while stalled.
- Single-requester streaming: one requester alone gets back-to-back grants every cycle, provided it drains each cycle.
- Fairness: under continuous contention with immediate drains, grants strictly alternate 0,1,0,1.
- last_grant updates only on an accept, never on idle cycles.
- Reset mid-operation: a pending result is discarded and no response is ever produced for it.
- Result width: no arithmetic is done in this block. Results are WIDTH bits with no flags.

Decomposition:
- alu_pkg (shared package):
  - FN class constants on FN[5:4]: FN_CMP=2'b00, FN_ARITH=2'b01, FN_BOOL=2'b10, FN_SHIFT=2'b11.
  - Full codes: FN_ADD=6'b010000, FN_SUB=6'b010001.
  - Type alu_req_t {a, b, fn}.
- Sub-module rr_arbiter2: two request bits in, last_grant and enable in, one-hot grant out, purely combinational. The slot register and last_grant state stay in the top level.

Test Plan:
1. Single add: req0 valid a=5 b=7 fn=FN_ADD, rsp0_ready=1 -> req0_ready=1 in cycle 0; alu_fn=6'b010000; rsp0_valid=1 with rsp0_y=12 in cycle 1; rsp1_valid stays 0.
2. Tie after reset: both valid every cycle, both rsp_ready=1 -> grants 0,1,0,1; rsp0_y/rsp1_y match each op; one result per cycle.
3. Backpressure: req0 sub a=10 b=3 accepted, rsp0_ready=0 for 4 cycles while req1 is valid -> rsp0_y=7 held and req1_ready=0 throughout. When rsp0_ready=1, req1 is granted in that same cycle.
4. Drain plus accept: slot holds a req1 result, rsp1_ready=1 and req0 valid in the same cycle -> req0_ready=1, and the next cycle shows rsp0_valid=1, rsp1_valid=0.
5. Reset mid-op: accept req1 with fn=FN_SUB, then assert n_rst=0 between edges -> rsp1_valid drops to 0 immediately. After release a tie grants requester 0 first.
6. Idle drive: no valid requests -> alu_a=0, alu_b=0, alu_fn=0, and last_grant is unchanged over 10 cycles.
